// File: rtl/ide_pkg.sv
// Shared constants and FSM state encoding for the IDE transfer engine.
package ide_pkg;

  localparam int IDE_DATA_W    = 16;
  localparam int IDE_BANK_AW   = 8;
  localparam int IDE_NUM_BANKS = 4;
  localparam int IDE_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BANK = 2'd1,
    ST_XFER      = 2'd2,
    ST_DONE      = 2'd3
  } ide_state_t;

endpackage

// File: rtl/ide_xfer_ram.sv
// Banked transfer buffer: dual-port RAM, registered read on both ports.
module ide_xfer_ram
  import ide_pkg::*;
#(
  parameter int DATA_W = IDE_DATA_W,
  parameter int AW     = $clog2(IDE_NUM_BANKS) + IDE_BANK_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     a_addr,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [AW-1:0]     b_addr,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [0:(2**AW)-1];
  logic [DATA_W-1:0] a_rdata_reg;
  logic [DATA_W-1:0] b_rdata_reg;

  // Port A is issued last so a host write overrides a CPU write to the same word.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
    if (a_we) mem[a_addr] <= a_wdata;
  end

  // Only the host-side output register is cleared; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) a_rdata_reg <= '0;
    else     a_rdata_reg <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    b_rdata_reg <= mem[b_addr];
  end

  assign a_rdata = a_rdata_reg;
  assign b_rdata = b_rdata_reg;

endmodule

// File: rtl/ide_xfer_engine.sv
// IDE PIO/DMA transfer engine moving words between the host bus and a
// multi-bank buffer shared with the CPU, with per-bank handshake flags.
module ide_xfer_engine
  import ide_pkg::*;
#(
  parameter int DATA_W    = IDE_DATA_W,
  parameter int BANK_AW   = IDE_BANK_AW,
  parameter int NUM_BANKS = IDE_NUM_BANKS,
  parameter int CNT_W     = IDE_CNT_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_start,
  input  logic                                  cfg_dir,
  input  logic                                  cfg_dma,
  input  logic [CNT_W-1:0]                      cfg_words,
  input  logic                                  host_rd,
  input  logic                                  host_wr,
  input  logic                                  host_sel,
  input  logic                                  host_dmack,
  input  logic [DATA_W-1:0]                     host_wdata,
  output logic [DATA_W-1:0]                     host_rdata,
  output logic                                  dmarq,
  input  logic [$clog2(NUM_BANKS)+BANK_AW-1:0]  cpu_addr,
  input  logic                                  cpu_we,
  input  logic [DATA_W-1:0]                     cpu_wdata,
  output logic [DATA_W-1:0]                     cpu_rdata,
  input  logic                                  cpu_bank_done,
  output logic                                  busy,
  output logic                                  irq_done,
  output logic                                  err_ovr
);

  localparam int BA_W = $clog2(NUM_BANKS);
  localparam int AW   = BA_W + BANK_AW;

  ide_state_t           state_reg, state_next;
  logic [BANK_AW-1:0]   pos_reg, pos_next;
  logic [BA_W-1:0]      bank_reg, bank_next;
  logic [CNT_W:0]       remaining_reg, remaining_next;
  logic [NUM_BANKS-1:0] ready_reg, ready_next;
  logic                 dir_reg, dma_reg;
  logic                 dmarq_reg, err_reg;

  logic            start_ok, eff_dir, eff_dma, strobe, xfer_strobe, leave;
  logic [BA_W-1:0] cpu_bank;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;

  assign start_ok = cfg_start && (state_reg == ST_IDLE);
  assign cpu_bank = cpu_addr[AW-1:BANK_AW];

  // While idle there is no latched mode, so stray strobes are judged against the live config.
  assign eff_dir     = (state_reg == ST_IDLE) ? cfg_dir : dir_reg;
  assign eff_dma     = (state_reg == ST_IDLE) ? cfg_dma : dma_reg;
  assign strobe      = (eff_dir ? host_wr : host_rd) && (eff_dma ? host_dmack : host_sel);
  assign xfer_strobe = strobe && (state_reg == ST_XFER);
  assign leave       = xfer_strobe && (pos_reg == '1);

  // A CPU release landing on the bank being left in the same cycle keeps the flag set.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_ready
    logic set_hit, clr_hit;
    assign set_hit = cpu_bank_done && (cpu_bank == BA_W'(gi));
    assign clr_hit = leave && (bank_reg == BA_W'(gi));
    assign ready_next[gi] = start_ok ? cfg_dir : (set_hit | (ready_reg[gi] & ~clr_hit));
  end

  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    bank_next      = bank_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next     = ST_WAIT_BANK;
          pos_next       = '0;
          bank_next      = '0;
          remaining_next = (cfg_words == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, cfg_words};
        end
      end
      ST_WAIT_BANK: begin
        if (ready_next[bank_reg]) state_next = ST_XFER;
      end
      ST_XFER: begin
        if (strobe) begin
          pos_next       = pos_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (pos_reg == '1) bank_next = bank_reg + 1'b1;
          if (remaining_reg == (CNT_W+1)'(1)) state_next = ST_DONE;
          else if (pos_reg == '1)            state_next = ST_WAIT_BANK;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pos_reg       <= '0;
      bank_reg      <= '0;
      remaining_reg <= '0;
      ready_reg     <= '0;
      dir_reg       <= 1'b0;
      dma_reg       <= 1'b0;
      dmarq_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      bank_reg      <= bank_next;
      remaining_reg <= remaining_next;
      ready_reg     <= ready_next;
      if (start_ok) begin
        dir_reg <= cfg_dir;
        dma_reg <= cfg_dma;
      end
      dmarq_reg <= (state_next == ST_XFER) && dma_reg;
      if (cfg_start)                            err_reg <= 1'b0;
      else if (strobe && state_reg != ST_XFER)  err_reg <= 1'b1;
    end
  end

  // Reads are issued at the upcoming position so host_rdata tracks the position
  // register without an extra cycle; a write cycle must address the current word.
  assign ram_we   = xfer_strobe && dir_reg;
  assign ram_addr = ram_we ? {bank_reg, pos_reg} : {bank_next, pos_next};

  ide_xfer_ram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_addr  (ram_addr),
    .a_we    (ram_we),
    .a_wdata (host_wdata),
    .a_rdata (host_rdata),
    .b_addr  (cpu_addr),
    .b_we    (cpu_we),
    .b_wdata (cpu_wdata),
    .b_rdata (cpu_rdata)
  );

  assign dmarq    = dmarq_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign irq_done = (state_reg == ST_DONE);
  assign err_ovr  = err_reg;

endmodule

// File: tb/tb_ide_xfer_engine.sv
// Directed self-checking bench for ide_xfer_engine (default parameters).
module tb_ide_xfer_engine;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0, cfg_dir = 1'b0, cfg_dma = 1'b0;
  logic [15:0] cfg_words = '0;
  logic        host_rd = 1'b0, host_wr = 1'b0, host_sel = 1'b0, host_dmack = 1'b0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        dmarq;
  logic [AW-1:0] cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_bank_done = 1'b0;
  logic        busy, irq_done, err_ovr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ide_xfer_engine dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_dma(cfg_dma), .cfg_words(cfg_words),
    .host_rd(host_rd), .host_wr(host_wr), .host_sel(host_sel), .host_dmack(host_dmack),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .dmarq(dmarq),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_bank_done(cpu_bank_done), .busy(busy), .irq_done(irq_done), .err_ovr(err_ovr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [15:0] words, input logic dir, input logic dma);
    cfg_words = words; cfg_dir = dir; cfg_dma = dma; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic fill_bank(input int b, input logic [15:0] base);
    for (int i = 0; i < 256; i++) begin
      cpu_we = 1'b1; cpu_addr = AW'(b * 256 + i); cpu_wdata = base + 16'(i);
      tick();
    end
    cpu_we = 1'b0;
  endtask

  task automatic bank_done(input int b);
    cpu_addr = AW'(b * 256); cpu_bank_done = 1'b1;
    tick();
    cpu_bank_done = 1'b0;
  endtask

  task automatic wait_dmarq(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if (dmarq) ok = 1'b1;
      else tick();
    end
    if (dmarq) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (dmarq !== 1'b0)      begin bad++; $display("FAIL reset_dmarq: got %b want 0", dmarq); end
    total++; if (irq_done !== 1'b0)   begin bad++; $display("FAIL reset_irq: got %b want 0", irq_done); end
    total++; if (err_ovr !== 1'b0)    begin bad++; $display("FAIL reset_err: got %b want 0", err_ovr); end
    total++; if (host_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0000", host_rdata); end
    rst = 1'b0;
    tick();
    $display("reset: checked idle outputs");
  endtask

  task automatic test_pio_read();
    fill_bank(0, 16'h0000);
    start_xfer(16'd256, 1'b0, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pio_busy: got %b want 1", busy); end
    bank_done(0);
    host_sel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      host_rd = 1'b1;
      total++;
      if (host_rdata !== 16'(i) || irq_done !== 1'b0) begin
        bad++; $display("FAIL pio_word %0d: got %h irq %b want %h irq 0", i, host_rdata, irq_done, 16'(i));
      end
      tick();
      host_rd = 1'b0;
    end
    total++; if (irq_done !== 1'b1) begin bad++; $display("FAIL pio_irq: got %b want 1", irq_done); end
    tick();
    total++;
    if (irq_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL pio_idle: irq %b busy %b want 0 0", irq_done, busy);
    end
    host_sel = 1'b0;
    $display("pio_read: 256 words read from bank 0");
  endtask

  task automatic test_dma_read();
    int n;
    start_xfer(16'd600, 1'b0, 1'b1);
    tick(); tick(); tick();
    total++; if (dmarq !== 1'b0) begin bad++; $display("FAIL dma_nobank: dmarq %b want 0", dmarq); end
    for (int b = 0; b < 3; b++) begin
      fill_bank(b, 16'hA000 + 16'(b * 256));
      cpu_addr = AW'(b * 256); cpu_bank_done = 1'b1;
      total++; if (dmarq !== 1'b0) begin bad++; $display("FAIL dma_pre_done bank %0d: dmarq %b want 0", b, dmarq); end
      tick();
      cpu_bank_done = 1'b0;
      total++; if (dmarq !== 1'b1) begin bad++; $display("FAIL dma_reassert bank %0d: dmarq %b want 1", b, dmarq); end
      n = (b == 2) ? 88 : 256;
      for (int i = 0; i < n; i++) begin
        host_rd = 1'b1; host_dmack = 1'b1;
        total++;
        if (host_rdata !== 16'hA000 + 16'(b * 256 + i) || dmarq !== 1'b1) begin
          bad++; $display("FAIL dma_word %0d: got %h dmarq %b want %h dmarq 1",
                          b * 256 + i, host_rdata, dmarq, 16'hA000 + 16'(b * 256 + i));
        end
        tick();
        host_rd = 1'b0; host_dmack = 1'b0;
      end
      if (b < 2) begin
        total++;
        if (dmarq !== 1'b0 || busy !== 1'b1 || irq_done !== 1'b0) begin
          bad++; $display("FAIL dma_drop word %0d: dmarq %b busy %b irq %b want 0 1 0", (b + 1) * 256, dmarq, busy, irq_done);
        end
      end
    end
    total++;
    if (irq_done !== 1'b1 || dmarq !== 1'b0) begin
      bad++; $display("FAIL dma_done: irq %b dmarq %b want 1 0", irq_done, dmarq);
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dma_idle: busy %b want 0", busy); end
    $display("dma_read: 600 words over 3 banks");
  endtask

  task automatic test_dma_write();
    bit ok;
    logic [15:0] exp;
    start_xfer(16'd1088, 1'b1, 1'b1);
    for (int w = 0; w < 1024; w++) begin
      wait_dmarq(8, ok);
      if (!ok) begin
        total++; bad++; $display("FAIL dmaw_timeout word %0d: dmarq %b want 1", w, dmarq);
        break;
      end
      host_wr = 1'b1; host_dmack = 1'b1; host_wdata = 16'h5000 + 16'(w);
      tick();
      host_wr = 1'b0; host_dmack = 1'b0;
    end
    repeat (10) tick();
    total++;
    if (dmarq !== 1'b0 || busy !== 1'b1 || irq_done !== 1'b0) begin
      bad++; $display("FAIL dmaw_stall: dmarq %b busy %b irq %b want 0 1 0", dmarq, busy, irq_done);
    end
    for (int a = 0; a < 1024; a++) begin
      cpu_addr = AW'(a);
      tick();
      total++;
      if (cpu_rdata !== 16'h5000 + 16'(a)) begin
        bad++; $display("FAIL dmaw_readback addr %0d: got %h want %h", a, cpu_rdata, 16'h5000 + 16'(a));
      end
    end
    total++;
    if (dmarq !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL dmaw_still_stalled: dmarq %b busy %b want 0 1", dmarq, busy);
    end
    bank_done(0);
    for (int w = 0; w < 64; w++) begin
      wait_dmarq(8, ok);
      if (!ok) begin
        total++; bad++; $display("FAIL dmaw_resume_timeout word %0d: dmarq %b want 1", w, dmarq);
        break;
      end
      host_wr = 1'b1; host_dmack = 1'b1; host_wdata = 16'h6000 + 16'(w);
      if (w == 0) begin cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = 16'hDEAD; end
      tick();
      host_wr = 1'b0; host_dmack = 1'b0; cpu_we = 1'b0;
    end
    total++; if (irq_done !== 1'b1) begin bad++; $display("FAIL dmaw_irq: got %b want 1", irq_done); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dmaw_idle: busy %b want 0", busy); end
    for (int a = 0; a < 65; a++) begin
      exp = (a < 64) ? 16'h6000 + 16'(a) : 16'h5000 + 16'(a);
      cpu_addr = AW'(a);
      tick();
      total++;
      if (cpu_rdata !== exp) begin
        bad++; $display("FAIL dmaw_bank0_readback addr %0d: got %h want %h", a, cpu_rdata, exp);
      end
    end
    $display("dma_write: 1088 words, stall at bank 0 wrap, readback done");
  endtask

  task automatic test_error();
    cfg_dir = 1'b0; cfg_dma = 1'b0; host_sel = 1'b1; host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    total++;
    if (err_ovr !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL err_set: err %b busy %b want 1 0", err_ovr, busy);
    end
    repeat (5) tick();
    total++; if (err_ovr !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_ovr); end
    start_xfer(16'd4, 1'b0, 1'b0);
    total++; if (err_ovr !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err_ovr); end
    bank_done(0);
    for (int i = 0; i < 4; i++) begin
      host_rd = 1'b1;
      tick();
      host_rd = 1'b0;
    end
    total++;
    if (irq_done !== 1'b1 || err_ovr !== 1'b0) begin
      bad++; $display("FAIL err_xfer: irq %b err %b want 1 0", irq_done, err_ovr);
    end
    tick();
    host_sel = 1'b0;
    $display("error: idle strobe flagged and cleared by start");
  endtask

  task automatic test_reset_mid();
    bit irq_seen;
    bit ok;
    fill_bank(0, 16'h3300);
    start_xfer(16'd600, 1'b0, 1'b1);
    bank_done(0);
    for (int i = 0; i < 100; i++) begin
      host_rd = 1'b1; host_dmack = 1'b1;
      tick();
      host_rd = 1'b0; host_dmack = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (dmarq !== 1'b0 || busy !== 1'b0 || irq_done !== 1'b0) begin
      bad++; $display("FAIL rstmid_state: dmarq %b busy %b irq %b want 0 0 0", dmarq, busy, irq_done);
    end
    irq_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (irq_done) irq_seen = 1'b1;
    end
    total++; if (irq_seen !== 1'b0) begin bad++; $display("FAIL rstmid_irq: seen %b want 0", irq_seen); end
    start_xfer(16'd8, 1'b0, 1'b1);
    bank_done(0);
    for (int i = 0; i < 8; i++) begin
      wait_dmarq(4, ok);
      host_rd = 1'b1; host_dmack = 1'b1;
      total++;
      if (!ok || host_rdata !== 16'h3300 + 16'(i)) begin
        bad++; $display("FAIL rstmid_word %0d: got %h dmarq %b want %h dmarq 1", i, host_rdata, dmarq, 16'h3300 + 16'(i));
      end
      tick();
      host_rd = 1'b0; host_dmack = 1'b0;
    end
    total++; if (irq_done !== 1'b1) begin bad++; $display("FAIL rstmid_irq_after: got %b want 1", irq_done); end
    tick();
    $display("reset_mid: abort at word 100, follow-up 8 words");
  endtask

  task automatic test_words_zero();
    bit lost;
    bit irq_seen;
    irq_seen = 1'b0;
    start_xfer(16'd0, 1'b0, 1'b1);
    for (int b = 0; b < 256; b++) begin
      bank_done(b % 4);
      lost = 1'b0;
      for (int i = 0; i < 256; i++) begin
        if (dmarq !== 1'b1) lost = 1'b1;
        if (irq_done) irq_seen = 1'b1;
        host_rd = 1'b1; host_dmack = 1'b1;
        tick();
        host_rd = 1'b0; host_dmack = 1'b0;
      end
      total++;
      if (lost || dmarq !== 1'b0) begin
        bad++; $display("FAIL zero_bank %0d: dmarq_lost %b dmarq_end %b want 0 0", b, lost, dmarq);
      end
      if (b < 255 && irq_done) irq_seen = 1'b1;
    end
    total++; if (irq_seen !== 1'b0) begin bad++; $display("FAIL zero_early_irq: seen %b want 0", irq_seen); end
    total++; if (irq_done !== 1'b1) begin bad++; $display("FAIL zero_irq: got %b want 1", irq_done); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle: busy %b want 0", busy); end
    $display("words_zero: 65536 words over 256 bank passes");
  endtask

  initial begin
    test_reset();
    test_pio_read();
    test_dma_read();
    test_dma_write();
    test_error();
    test_reset_mid();
    test_words_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
